rca_sbb_event_coalescer: RTL and testbench

//  Sits between the branch unit and the RCA profiler. Qualifies taken short-backward-branch (SBB)

---
 rtl/rca_config_pkg.sv | 16 +
 rtl/rca_event_fifo.sv | 56 +++++
 rtl/rca_sbb_event_coalescer.sv | 127 ++++++++++++
 tb/tb_rca_sbb_event_coalescer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rca_config_pkg.sv
// Shared RCA configuration: core width, SBB offset limit and the event record type.
// The offset limit is shared with the profiler so both agree on what counts as a short loop.
package rca_config;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned SBB_COUNT_W = 8;

    // Most negative offset that still counts as a short backward branch is SBB_MAX_OFFSET + 1.
    localparam logic signed [20:0] SBB_MAX_OFFSET = -21'sd1024;

    typedef struct packed {
        logic [XLEN-1:0]        pc;
        logic [SBB_COUNT_W-1:0] count;
    } sbb_event_t;

endpackage

// File: rtl/rca_event_fifo.sv
// Generic registered FIFO with wrap-bit pointers and a synchronous clear.
// No bypass: a write becomes visible at the head on the following cycle.
module rca_event_fifo
    import rca_config::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         item_t = sbb_event_t
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  clear,
    input  logic  push,
    input  item_t push_data,
    input  logic  pop,
    output item_t head,
    output logic  full,
    output logic  empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    item_t       mem_q [DEPTH];
    logic        do_pop;
    logic        do_push;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_data;
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rca_sbb_event_coalescer.sv
// Qualifies taken short-backward branches, merges consecutive hits on one PC into a
// {pc,count} record and queues records for the profiler; overflow is counted, never stalls.
module rca_sbb_event_coalescer
    import rca_config::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned COUNT_W    = 8,
    parameter int unsigned IDLE_FLUSH = 16,
    parameter int unsigned DROP_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                branch_instr_issue,
    input  logic                branch_taken,
    input  logic [XLEN-1:0]     branch_instr_pc,
    input  logic signed [20:0]  branch_pc_offset,
    input  logic                profiler_lock,
    input  logic                flush,
    output logic                evt_valid,
    output logic [XLEN-1:0]     evt_pc,
    output logic [COUNT_W-1:0]  evt_count,
    input  logic                evt_ready,
    output logic [DROP_W-1:0]   dropped_count
);

    localparam int unsigned       IdleW    = $clog2(IDLE_FLUSH + 1);
    localparam logic [COUNT_W-1:0] CountMax = '1;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [COUNT_W-1:0] count;
    } rec_t;

    typedef enum logic {StEmpty, StOpen} state_e;

    state_e             state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [IdleW-1:0]   idle_q, idle_d;
    logic [DROP_W-1:0]  dropped_q, dropped_d;

    logic hit;
    logic push;
    logic pop;
    logic full;
    logic empty;
    rec_t push_rec;
    rec_t head;

    assign hit = branch_instr_issue & branch_taken & ~profiler_lock &
                 (branch_pc_offset < 21'sd0) & (branch_pc_offset > SBB_MAX_OFFSET);

    assign push_rec = '{pc: pc_q, count: cnt_q};
    assign pop      = ~empty & evt_ready;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        idle_d    = idle_q;
        push      = 1'b0;
        dropped_d = dropped_q;
        if (flush) begin
            // Any same-cycle hit is discarded along with the open record.
            state_d = StEmpty;
            idle_d  = '0;
        end else if (hit) begin
            idle_d = '0;
            if (state_q == StOpen && branch_instr_pc == pc_q && cnt_q != CountMax) begin
                cnt_d = cnt_q + COUNT_W'(1);
            end else begin
                push    = (state_q == StOpen);
                state_d = StOpen;
                pc_d    = branch_instr_pc;
                cnt_d   = COUNT_W'(1);
            end
        end else if (state_q == StOpen) begin
            if (idle_q == IdleW'(IDLE_FLUSH - 1)) begin
                push    = 1'b1;
                state_d = StEmpty;
                idle_d  = '0;
            end else begin
                idle_d = idle_q + IdleW'(1);
            end
        end
        if (push && full && !pop && dropped_q != '1) begin
            dropped_d = dropped_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StEmpty;
            pc_q      <= '0;
            cnt_q     <= '0;
            idle_q    <= '0;
            dropped_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            idle_q    <= idle_d;
            dropped_q <= dropped_d;
        end
    end

    rca_event_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .item_t (rec_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (push),
        .push_data (push_rec),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    assign evt_valid     = ~empty;
    assign evt_pc        = head.pc;
    assign evt_count     = head.count;
    assign dropped_count = dropped_q;

endmodule

// File: tb/tb_rca_sbb_event_coalescer.sv
// Directed bench for the SBB event coalescer: merging, qualification, overflow, flush, reset.
module tb_rca_sbb_event_coalescer;
    import rca_config::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              branch_instr_issue;
    logic              branch_taken;
    logic [XLEN-1:0]   branch_instr_pc;
    logic signed [20:0] branch_pc_offset;
    logic              profiler_lock;
    logic              flush;
    logic              evt_valid;
    logic [XLEN-1:0]   evt_pc;
    logic [7:0]        evt_count;
    logic              evt_ready;
    logic [15:0]       dropped_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rca_sbb_event_coalescer #(
        .FIFO_DEPTH (4),
        .COUNT_W    (8),
        .IDLE_FLUSH (16),
        .DROP_W     (16)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .branch_instr_issue (branch_instr_issue),
        .branch_taken       (branch_taken),
        .branch_instr_pc    (branch_instr_pc),
        .branch_pc_offset   (branch_pc_offset),
        .profiler_lock      (profiler_lock),
        .flush              (flush),
        .evt_valid          (evt_valid),
        .evt_pc             (evt_pc),
        .evt_count          (evt_count),
        .evt_ready          (evt_ready),
        .dropped_count      (dropped_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iss, input logic tkn, input logic [XLEN-1:0] pc,
                         input logic signed [20:0] off, input logic lck);
        branch_instr_issue = iss;
        branch_taken       = tkn;
        branch_instr_pc    = pc;
        branch_pc_offset   = off;
        profiler_lock      = lck;
        tick();
    endtask

    task automatic hit(input logic [XLEN-1:0] pc);
        drive(1'b1, 1'b1, pc, -21'sd8, 1'b0);
    endtask

    task automatic quiet();
        branch_instr_issue = 1'b0;
        branch_taken       = 1'b0;
        profiler_lock      = 1'b0;
    endtask

    task automatic wait_evt(input int max_cycles, output int n);
        n = 0;
        while (!evt_valid && n < max_cycles) begin
            tick();
            n++;
        end
    endtask

    int  n;
    logic seen;

    initial begin
        rst = 1'b1; flush = 1'b0; evt_ready = 1'b0;
        branch_instr_pc = '0; branch_pc_offset = '0;
        quiet();
        tick(); tick();
        check("reset_valid", evt_valid, 0);
        check("reset_pc", evt_pc, 0);
        check("reset_count", evt_count, 0);
        check("reset_dropped", dropped_count, 0);
        rst = 1'b0;
        tick();

        // 1: ten consecutive hits merge into one record
        evt_ready = 1'b1;
        for (int i = 0; i < 10; i++) hit(32'h100);
        quiet();
        wait_evt(40, n);
        check("t1_latency", n, 16);
        check("t1_pc", evt_pc, 32'h100);
        check("t1_count", evt_count, 10);
        tick();
        check("t1_popped", evt_valid, 0);

        // 2: pc change closes the record; order preserved
        evt_ready = 1'b0;
        hit(32'h100); hit(32'h100); hit(32'h200);
        quiet();
        check("t2_first_valid", evt_valid, 1);
        check("t2_first_pc", evt_pc, 32'h100);
        check("t2_first_count", evt_count, 2);
        evt_ready = 1'b1;
        tick();
        check("t2_after_pop", evt_valid, 0);
        wait_evt(40, n);
        check("t2_second_latency", n, 15);
        check("t2_second_pc", evt_pc, 32'h200);
        check("t2_second_count", evt_count, 1);
        tick();

        // 3: offset boundary just inside the window qualifies
        drive(1'b1, 1'b1, 32'h240, SBB_MAX_OFFSET + 21'sd1, 1'b0);
        quiet();
        wait_evt(40, n);
        check("t3_edge_latency", n, 16);
        check("t3_edge_pc", evt_pc, 32'h240);
        check("t3_edge_count", evt_count, 1);
        tick();

        // 3: non-qualifying branches produce nothing
        seen = 1'b0;
        drive(1'b1, 1'b1, 32'h300, 21'sd8, 1'b0);
        drive(1'b1, 1'b1, 32'h304, 21'sd0, 1'b0);
        drive(1'b1, 1'b1, 32'h308, SBB_MAX_OFFSET, 1'b0);
        drive(1'b1, 1'b1, 32'h30c, SBB_MAX_OFFSET - 21'sd4, 1'b0);
        drive(1'b1, 1'b0, 32'h310, -21'sd8, 1'b0);
        drive(1'b1, 1'b1, 32'h314, -21'sd8, 1'b1);
        drive(1'b0, 1'b1, 32'h318, -21'sd8, 1'b0);
        quiet();
        for (int i = 0; i < 20; i++) begin
            seen |= evt_valid;
            tick();
        end
        check("t3_no_events", seen, 0);

        // 4: overflow with the profiler stalled
        evt_ready = 1'b0;
        for (int i = 0; i < 6; i++) hit(32'h1000 + 32'(i * 4));
        quiet();
        check("t4_valid", evt_valid, 1);
        check("t4_dropped", dropped_count, 1);
        check("t4_head_pc", evt_pc, 32'h1000);
        for (int i = 0; i < 5; i++) tick();
        check("t4_head_stable_pc", evt_pc, 32'h1000);
        check("t4_head_stable_count", evt_count, 1);
        flush = 1'b1; tick(); flush = 1'b0;
        check("t4_flushed", evt_valid, 0);
        check("t4_dropped_kept", dropped_count, 1);

        // 5: count saturation splits a long burst
        for (int i = 0; i < 300; i++) hit(32'h500);
        quiet();
        check("t5_first_pc", evt_pc, 32'h500);
        check("t5_first_count", evt_count, 255);
        evt_ready = 1'b1;
        tick();
        wait_evt(40, n);
        check("t5_second_latency", n, 15);
        check("t5_second_count", evt_count, 45);
        tick();

        // 6: flush with buffered records, open record and a same-cycle hit
        evt_ready = 1'b0;
        hit(32'h600); hit(32'h604); hit(32'h608);
        check("t6_buffered", evt_valid, 1);
        flush = 1'b1;
        hit(32'h60c);
        flush = 1'b0;
        quiet();
        check("t6_flush_valid", evt_valid, 0);
        check("t6_flush_dropped", dropped_count, 1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            seen |= evt_valid;
            tick();
        end
        check("t6_nothing_later", seen, 0);

        // 6: reset mid-burst clears everything
        hit(32'h700); hit(32'h704); hit(32'h700); hit(32'h700);
        check("t6_pre_reset_valid", evt_valid, 1);
        rst = 1'b1;
        hit(32'h700);
        rst = 1'b0;
        quiet();
        check("t6_rst_valid", evt_valid, 0);
        check("t6_rst_pc", evt_pc, 0);
        check("t6_rst_count", evt_count, 0);
        check("t6_rst_dropped", dropped_count, 0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            seen |= evt_valid;
            tick();
        end
        check("t6_rst_nothing_later", seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
